uart_rx_fsm: RTL
================

Name: uart_rx_fsm

Overview:
Control FSM of the UART receiver. It sits beside the edge/bit counter and drives that counter's enable. It consumes the counter's edge_count/bit_count and sequences the data sampler, deserializer and start/parity/stop checkers. It emits a one-cycle data_valid per good frame plus per-frame error flags.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
EDGE_W, 5, width of edge_count (supports Prescale up to 32).
BIT_W, 4, width of bit_count.

Ports:
clk  in  1  receiver oversampling clock.
rst  in  1  reset, asynchronous, active-low.
RX_IN  in  1  serial line, idle high.
PAR_EN  in  1  parity bit present in frame.
Prescale  in  6  oversampling ratio; legal values 8, 16, 32.
edge_count  in  EDGE_W  edge counter value (0..P-1; held at 0 while counter_enable=0).
bit_count  in  BIT_W  bit index within frame (0=start, 1..DATA_WIDTH data, then parity/stop).
strt_glitch  in  1  start checker result; valid while strt_chk_en=1.
par_err  in  1  parity checker result; valid while par_chk_en=1.
stp_err  in  1  stop checker result; valid while stp_chk_en=1.
counter_enable  out  1  run edge/bit counter; low clears it.
data_samp_en  out  1  enable 3-point majority sampler.
strt_chk_en  out  1  start-check strobe.
deser_en  out  1  shift sampled bit into deserializer.
par_chk_en  out  1  parity-check strobe.
stp_chk_en  out  1  stop-check strobe.
data_valid  out  1  one-cycle pulse: frame received without error.
parity_error  out  1  one-cycle pulse: frame ended with parity error.
framing_error  out  1  one-cycle pulse: frame ended with stop error.

Behaviour:
- Reset (rst=0, async): state IDLE, P_q=0, error latches cleared, all outputs 0. Mid-frame reset aborts the frame; no flags pulse.
- P_q: Prescale is latched on the IDLE->START transition; all decode below uses P_q. If Prescale is not 8/16/32 at detection, stay IDLE.
- Decode points: SAMP = P_q/2+2 (sampler output valid; checks strobe here); LAST = P_q-1; STOP_END = P_q/2+3.
- Output style: state registered; the enables are Moore/edge_count decodes, combinational from registered state and inputs, with no added latency.
- counter_enable=1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE.
- data_samp_en follows counter_enable.
- IDLE: RX_IN=0 -> START. The first START cycle sees edge_count=0.
- START: strt_chk_en=1 at edge_count==SAMP.
  - If strt_glitch=1 in that cycle -> IDLE next cycle, with no flags.
  - Else at edge_count==LAST -> DATA.
- DATA: deser_en=1 at edge_count==SAMP. At edge_count==LAST with bit_count==DATA_WIDTH -> PARITY if PAR_EN, else STOP.
- PARITY: par_chk_en=1 at SAMP; par_err=1 there sets the parity latch. At LAST -> STOP.
- STOP: stp_chk_en=1 at SAMP; stp_err=1 there sets the framing latch. At edge_count==STOP_END -> DONE. The early exit leaves a half-bit margin for back-to-back frames.
- DONE (1 cycle):
  - data_valid = !(par latch | frm latch).
  - parity_error and framing_error reflect their latches; both can be 1 together.
  - Latches clear.
  - Next state is START if RX_IN=0 (back-to-back frame; counter already cleared by enable=0 this cycle), else IDLE.
- PAR_EN and Prescale changes mid-frame are ignored: P_q is held, and PAR_EN is sampled only at the DATA exit.
- Frame timing: with RX_IN low first seen at cycle T0, DONE occurs at T0 + 1 + P_q*(1+DATA_WIDTH+PAR_EN) + STOP_END + 1.
- Unreachable state encodings -> IDLE.

Decomposition:
- Shared package uart_rx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, DONE);
  - legal prescale constants 8/16/32;
  - helper functions for SAMP/LAST/STOP_END.
- No sub-module. The decode-point comparator may be a local function.

Test Plan:
- P=8, PAR_EN=0, RX_IN low at T0=0, frame 0xA5 with good stop -> deser_en pulses at edge 6 of bits 1..8, data_valid=1 at cycle 81 only, errors 0.
- P=16, PAR_EN=1, even-parity frame 0x3C, checker par_err=1 -> par_chk_en at edge 10 of bit 9; at DONE parity_error=1, data_valid=0.
- P=16, RX_IN low 2 cycles, strt_glitch=1 at edge 10 -> IDLE next cycle, counter_enable=0, no data_valid.
- P=32, stp_err=1 -> stp_chk_en at edge 18; framing_error=1 at DONE, one cycle after edge_count=19 of the stop bit.
- Two back-to-back P=8 frames with RX_IN=0 at DONE -> DONE->START directly, edge_count restarts at 0, two data_valid pulses 81 cycles apart.
- rst low mid-DATA -> all outputs 0 asynchronously. Prescale=12 with RX_IN=0 -> remains IDLE.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and decode-point helpers for the UART receiver control path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic prescale_legal(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  // Majority sampler output is valid two edges after mid-bit.
  function automatic logic [5:0] samp_point(input logic [5:0] p);
    return (p >> 1) + 6'd2;
  endfunction

  function automatic logic [5:0] last_point(input logic [5:0] p);
    return p - 6'd1;
  endfunction

  function automatic logic [5:0] stop_end_point(input logic [5:0] p);
    return (p >> 1) + 6'd3;
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receiver sequencer: drives the edge/bit counter enable and strobes the
// sampler, deserializer and start/parity/stop checkers; reports per-frame status.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int EDGE_W     = 5,
  parameter int BIT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic [5:0]        Prescale,
  input  logic [EDGE_W-1:0] edge_count,
  input  logic [BIT_W-1:0]  bit_count,
  input  logic              strt_glitch,
  input  logic              par_err,
  input  logic              stp_err,
  output logic              counter_enable,
  output logic              data_samp_en,
  output logic              strt_chk_en,
  output logic              deser_en,
  output logic              par_chk_en,
  output logic              stp_chk_en,
  output logic              data_valid,
  output logic              parity_error,
  output logic              framing_error
);

  rx_state_e  state_q, state_d;
  logic [5:0] p_q, p_d;
  logic       par_err_q, par_err_d;
  logic       frm_err_q, frm_err_d;

  logic [5:0] edge_ext;
  logic       at_samp, at_last, at_stop_end, last_data_bit;

  assign edge_ext      = 6'(edge_count);
  assign at_samp       = (edge_ext == samp_point(p_q));
  assign at_last       = (edge_ext == last_point(p_q));
  assign at_stop_end   = (edge_ext == stop_end_point(p_q));
  assign last_data_bit = (bit_count == BIT_W'(DATA_WIDTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      p_q       <= 6'd0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    p_d            = p_q;
    par_err_d      = par_err_q;
    frm_err_d      = frm_err_q;
    counter_enable = 1'b0;
    strt_chk_en    = 1'b0;
    deser_en       = 1'b0;
    par_chk_en     = 1'b0;
    stp_chk_en     = 1'b0;
    data_valid     = 1'b0;
    parity_error   = 1'b0;
    framing_error  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!RX_IN && prescale_legal(Prescale)) begin
          state_d = START;
          p_d     = Prescale;
        end
      end
      START: begin
        counter_enable = 1'b1;
        strt_chk_en    = at_samp;
        if (at_samp && strt_glitch) state_d = IDLE;
        else if (at_last)           state_d = DATA;
      end
      DATA: begin
        counter_enable = 1'b1;
        deser_en       = at_samp;
        if (at_last && last_data_bit) state_d = PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        counter_enable = 1'b1;
        par_chk_en     = at_samp;
        if (at_samp && par_err) par_err_d = 1'b1;
        if (at_last)            state_d   = STOP;
      end
      STOP: begin
        counter_enable = 1'b1;
        stp_chk_en     = at_samp;
        if (at_samp && stp_err) frm_err_d = 1'b1;
        // Leave half a bit early so a following start edge is not missed.
        if (at_stop_end)        state_d   = DONE;
      end
      DONE: begin
        data_valid    = !(par_err_q || frm_err_q);
        parity_error  = par_err_q;
        framing_error = frm_err_q;
        par_err_d     = 1'b0;
        frm_err_d     = 1'b0;
        state_d       = RX_IN ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_samp_en = counter_enable;

endmodule
